// File: rtl/mem_dbus.sv
// MEM pipeline stage: passes ALU results through and runs loads/stores on a req/ack data bus.
// Define ALIGN_CHECK_EN to trap misaligned halfword/word accesses via mem_excp_align.
module mem_dbus #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        stallreq,
`ifdef ALIGN_CHECK_EN
    output logic        mem_excp_align,
`endif
    output logic        bus_err
);

    // Counter only has to reach TIMEOUT_CYC-1, so clog2(TIMEOUT_CYC) bits suffice.
    localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   rd_buf;

    logic        is_byte, is_half, is_word, is_load, is_store, misalign, go;
    logic        timeout, done;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata, rdata_eff, ld_data, result;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        case (ex_mem_op)
            4'd1, 4'd2, 4'd6: is_byte = 1'b1;
            4'd3, 4'd4, 4'd7: is_half = 1'b1;
            4'd5, 4'd8:       is_word = 1'b1;
            default: ;
        endcase
    end

    assign is_load  = (ex_mem_op >= 4'd1) && (ex_mem_op <= 4'd5);
    assign is_store = (ex_mem_op >= 4'd6) && (ex_mem_op <= 4'd8);

`ifdef ALIGN_CHECK_EN
    assign misalign = (is_half && ex_mem_addr[0]) || (is_word && (ex_mem_addr[1:0] != 2'b00));
    assign mem_excp_align = !rst && misalign;
`else
    assign misalign = 1'b0;
`endif

    assign go = (is_load || is_store) && !misalign;

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    always_comb begin
        req_sel   = 4'b1111;
        req_wdata = ex_reg2;
        if (is_byte) begin
            req_sel   = 4'b1000 >> ex_mem_addr[1:0];
            req_wdata = {4{ex_reg2[7:0]}};
        end else if (is_half) begin
            req_sel   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
            req_wdata = {2{ex_reg2[15:0]}};
        end
    end

    always_comb begin
        rdata_eff = dbus_ack ? dbus_rdata : 32'd0;
        case (ex_mem_addr[1:0])
            2'b00:   ld_byte = rdata_eff[31:24];
            2'b01:   ld_byte = rdata_eff[23:16];
            2'b10:   ld_byte = rdata_eff[15:8];
            default: ld_byte = rdata_eff[7:0];
        endcase
        ld_half = ex_mem_addr[1] ? rdata_eff[15:0] : rdata_eff[31:16];
        case (ex_mem_op)
            4'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            4'd2:    ld_data = {24'd0, ld_byte};
            4'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
            4'd4:    ld_data = {16'd0, ld_half};
            default: ld_data = rdata_eff;
        endcase
        result = is_load ? ld_data : ex_wdata;
    end

    // A timeout completes like an ack whose data reads as zero (rdata_eff is 0 without ack).
    assign timeout = (TIMEOUT_CYC != 0) && (state == BUSY) && !dbus_ack && (cnt == CNT_LAST);
    assign done    = (state == BUSY) && (dbus_ack || timeout);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        stallreq = 1'b0;
        case (state)
            IDLE: if (go) begin
                state_n  = BUSY;
                stallreq = 1'b1;
            end
            BUSY: begin
                if (done) state_n = stall[4] ? HOLD : IDLE;
                else      stallreq = 1'b1;
            end
            HOLD: if (!stall[4]) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (rst) stallreq = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_sel   <= '0;
            dbus_wdata <= '0;
            bus_err    <= 1'b0;
            cnt        <= '0;
            rd_buf     <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    dbus_req   <= 1'b1;
                    dbus_we    <= is_store;
                    dbus_addr  <= {ex_mem_addr[31:2], 2'b00};
                    dbus_sel   <= req_sel;
                    dbus_wdata <= req_wdata;
                    cnt        <= '0;
                end
                BUSY: begin
                    if (done) begin
                        dbus_req <= 1'b0;
                        bus_err  <= timeout;
                        if (stall[4]) rd_buf <= result;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (rst)                mem_wdata = '0;
        else if (state == HOLD) mem_wdata = rd_buf;
        else                    mem_wdata = result;
    end

    assign mem_wd    = rst ? 5'd0  : ex_wd;
    assign mem_wreg  = !rst && ex_wreg && !misalign;
    assign mem_hi    = rst ? 32'd0 : ex_hi;
    assign mem_lo    = rst ? 32'd0 : ex_lo;
    assign mem_whilo = !rst && ex_whilo;

endmodule

// File: tb/tb_mem_dbus.sv
// Self-checking bench for mem_dbus: vector table (fixed + random) against a byte-lane model,
// plus hand-written HOLD, timeout and mid-access reset sequences.
module tb_mem_dbus;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic        ex_whilo;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr, ex_reg2;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        stallreq;
    logic        bus_err;
`ifdef ALIGN_CHECK_EN
    logic        mem_excp_align;
`endif

    mem_dbus #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .stallreq(stallreq),
`ifdef ALIGN_CHECK_EN
        .mem_excp_align(mem_excp_align),
`endif
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, reg2, rdata, wdat;
        int          lat;
        logic        wreg;
        logic [3:0]  xsel;
        logic [31:0] xbw, xres;
    } vec_t;

    vec_t tbl[$];

    // ---- reference model: access size, lanes and extraction by plain arithmetic ----
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
        logic [3:0] s = '0;
        int sz  = op_size(op);
        int a   = int'(addr[1:0]);
        int off = a - (a % sz);
        for (int o = 0; o < 4; o++)
            if (o >= off && o < off + sz) s[3-o] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_bw(input logic [3:0] op, input logic [31:0] reg2);
        int sz = op_size(op);
        logic [31:0] b = {24'd0, reg2[7:0]};
        logic [31:0] h = {16'd0, reg2[15:0]};
        if (sz == 1) return b * 32'h01010101;
        if (sz == 2) return h * 32'h00010001;
        return reg2;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        int sz  = op_size(op);
        int a   = int'(addr[1:0]);
        int off = a - (a % sz);
        longint m = longint'(1) << (8 * sz);
        longint v = (longint'(rd) >> (8 * (4 - off - sz))) % m;
        if ((op == 4'd1 || op == 4'd3) && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, reg2, rdata, wdat,
                                input int lat, input logic wreg, input logic [3:0] xsel,
                                input logic [31:0] xbw, xres);
        vec_t v;
        v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.wdat = wdat;
        v.lat = lat; v.wreg = wreg; v.xsel = xsel; v.xbw = xbw; v.xres = xres;
        return v;
    endfunction

    // One instruction through the stage with a slave that acks v.lat cycles after req.
    task automatic run_vec(input vec_t v);
        int nst, idx;
        bit fin;
        logic [4:0] wd;
        @(negedge clk);
        wd = 5'($urandom);
        stall = 6'd0; ex_mem_op = v.op; ex_mem_addr = v.addr; ex_reg2 = v.reg2;
        ex_wdata = v.wdat; ex_wreg = v.wreg; ex_wd = wd;
        ex_hi = $urandom; ex_lo = $urandom; ex_whilo = 1'($urandom);
        dbus_ack = 1'b0; dbus_rdata = $urandom;
        #1;
        chk("pass_hi", mem_hi, ex_hi);
        chk("pass_lo", mem_lo, ex_lo);
        chk("pass_whilo", mem_whilo, ex_whilo);
        if (op_size(v.op) == 0) begin
            chk("nomem_stall", stallreq, 0);
            chk("nomem_wdata", mem_wdata, v.wdat);
            chk("nomem_wreg", mem_wreg, v.wreg);
            @(negedge clk); ex_mem_op = 4'd0; #1;
            chk("nomem_req", dbus_req, 0);
            return;
        end
        chk("idle_stall", stallreq, 1);
        chk("idle_req", dbus_req, 0);
        nst = 1; idx = 0; fin = 1'b0;
        while (!fin && idx < 10) begin
            @(negedge clk);
            dbus_ack   = (idx == v.lat);
            dbus_rdata = dbus_ack ? v.rdata : $urandom;
            #1;
            chk("busy_req", dbus_req, 1);
            if (idx == 0) begin
                chk("bus_addr", dbus_addr, {v.addr[31:2], 2'b00});
                chk("bus_sel", dbus_sel, v.xsel);
                chk("bus_we", dbus_we, (v.op >= 4'd6));
                if (v.op >= 4'd6) chk("bus_wdata", dbus_wdata, v.xbw);
            end
            if (stallreq) nst++;
            else begin
                fin = 1'b1;
                chk("result", mem_wdata, v.xres);
                chk("wreg", mem_wreg, v.wreg);
                chk("wd", mem_wd, wd);
            end
            idx++;
        end
        chk("stall_cycles", nst, v.lat + 1);
        @(negedge clk);
        dbus_ack = 1'b0; ex_mem_op = 4'd0; #1;
        chk("req_drop", dbus_req, 0);
        chk("no_err", bus_err, 0);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; stall = 6'd0; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h1111_2222;
        ex_hi = 32'h3; ex_lo = 32'h4; ex_whilo = 1'b1; ex_mem_op = 4'd5;
        ex_mem_addr = 32'h100; ex_reg2 = 32'h5; dbus_ack = 1'b0; dbus_rdata = 32'h0;

        // Reset: registered and combinational outputs all read zero.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", dbus_req, 0);
        chk("rst_we", dbus_we, 0);
        chk("rst_addr", dbus_addr, 0);
        chk("rst_sel", dbus_sel, 0);
        chk("rst_bwdata", dbus_wdata, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_stall", stallreq, 0);
        chk("rst_wd", mem_wd, 0);
        chk("rst_wreg", mem_wreg, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hi", mem_hi, 0);
        chk("rst_whilo", mem_whilo, 0);
        @(negedge clk);
        rst = 1'b0; ex_mem_op = 4'd0;

        tbl.push_back(mk(4'd5, 32'h100, 32'h0, 32'h12345678, 32'h0, 3, 1'b1, 4'b1111, 32'h0, 32'h12345678));
        tbl.push_back(mk(4'd1, 32'h103, 32'h0, 32'h000000F0, 32'h0, 1, 1'b1, 4'b0001, 32'h0, 32'hFFFFFFF0));
        tbl.push_back(mk(4'd2, 32'h103, 32'h0, 32'h000000F0, 32'h0, 1, 1'b0, 4'b0001, 32'h0, 32'h000000F0));
        tbl.push_back(mk(4'd7, 32'h202, 32'hAAAABEEF, 32'h0, 32'h11, 2, 1'b0, 4'b0011, 32'hBEEFBEEF, 32'h11));
        tbl.push_back(mk(4'd4, 32'h102, 32'h0, 32'h1234ABCD, 32'h0, 0, 1'b1, 4'b0011, 32'h0, 32'h0000ABCD));
        tbl.push_back(mk(4'd3, 32'h100, 32'h0, 32'h80012345, 32'h0, 2, 1'b1, 4'b1100, 32'h0, 32'hFFFF8001));
        tbl.push_back(mk(4'd6, 32'h201, 32'h0000005A, 32'h0, 32'h22, 1, 1'b0, 4'b0100, 32'h5A5A5A5A, 32'h22));
        tbl.push_back(mk(4'd8, 32'h300, 32'hDEADBEEF, 32'h0, 32'h33, 0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h33));
        tbl.push_back(mk(4'd0, 32'h400, 32'h0, 32'h0, 32'h99, 0, 1'b1, 4'b0000, 32'h0, 32'h99));
        tbl.push_back(mk(4'd12, 32'h404, 32'h0, 32'h0, 32'hABC, 0, 1'b1, 4'b0000, 32'h0, 32'hABC));
`ifndef ALIGN_CHECK_EN
        // Low address bits below the access size are ignored.
        tbl.push_back(mk(4'd3, 32'h101, 32'h0, 32'h80012345, 32'h0, 1, 1'b1, 4'b1100, 32'h0, 32'hFFFF8001));
        tbl.push_back(mk(4'd8, 32'h303, 32'hCAFEF00D, 32'h0, 32'h44, 1, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h44));
`endif

        for (int i = 0; i < 24; i++) begin
            v.op = 4'($urandom_range(1, 8));
            v.addr = $urandom;
`ifdef ALIGN_CHECK_EN
            if (op_size(v.op) == 2) v.addr[0] = 1'b0;
            if (op_size(v.op) == 4) v.addr[1:0] = 2'b00;
`endif
            v.reg2 = $urandom; v.rdata = $urandom; v.wdat = $urandom;
            v.lat = int'($urandom_range(0, 3)); v.wreg = 1'($urandom);
            v.xsel = m_sel(v.op, v.addr);
            v.xbw  = m_bw(v.op, v.reg2);
            v.xres = (v.op <= 4'd5) ? m_load(v.op, v.addr, v.rdata) : v.wdat;
            tbl.push_back(v);
        end

        foreach (tbl[i]) run_vec(tbl[i]);

        // Completion while another stage stalls: result parked, no second request.
        @(negedge clk);
        ex_mem_op = 4'd5; ex_mem_addr = 32'h500; ex_wreg = 1'b1; dbus_ack = 1'b0; #1;
        chk("hold_idle_stall", stallreq, 1);
        @(negedge clk); #1;
        @(negedge clk);
        dbus_ack = 1'b1; dbus_rdata = 32'hCAFEBABE; stall = 6'b010000; #1;
        chk("hold_ack_stall", stallreq, 0);
        chk("hold_ack_data", mem_wdata, 32'hCAFEBABE);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            dbus_ack = 1'b0; dbus_rdata = $urandom; #1;
            chk("hold_stall", stallreq, 0);
            chk("hold_data", mem_wdata, 32'hCAFEBABE);
            chk("hold_req", dbus_req, 0);
        end
        @(negedge clk);
        stall = 6'd0; #1;
        chk("hold_rel_stall", stallreq, 0);
        chk("hold_rel_data", mem_wdata, 32'hCAFEBABE);
        chk("hold_rel_req", dbus_req, 0);
        @(negedge clk);
        ex_mem_op = 4'd0; ex_wdata = 32'h55; #1;
        chk("hold_idle_req", dbus_req, 0);
        chk("hold_idle_data", mem_wdata, 32'h55);

        // Timeout: four BUSY cycles without ack, then forced completion with zero data.
        @(negedge clk);
        ex_mem_op = 4'd5; ex_mem_addr = 32'h600; #1;
        chk("to_idle_stall", stallreq, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dbus_rdata = $urandom; #1;
            chk("to_busy_req", dbus_req, 1);
            chk("to_err_low", bus_err, 0);
            if (k < 3) chk("to_busy_stall", stallreq, 1);
            else begin
                chk("to_done_stall", stallreq, 0);
                chk("to_done_data", mem_wdata, 0);
            end
        end
        @(negedge clk);
        ex_mem_op = 4'd0; #1;
        chk("to_req_drop", dbus_req, 0);
        chk("to_err_pulse", bus_err, 1);
        @(negedge clk); #1;
        chk("to_err_clear", bus_err, 0);

        // Reset in the middle of an access, then a late ack that must be ignored.
        @(negedge clk);
        ex_mem_op = 4'd5; ex_mem_addr = 32'h700; ex_wd = 5'd9; #1;
        @(negedge clk); #1;
        chk("rb_busy_req", dbus_req, 1);
        @(negedge clk);
        rst = 1'b1; #1;
        chk("rb_stall", stallreq, 0);
        chk("rb_wd", mem_wd, 0);
        chk("rb_wdata", mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0; ex_mem_op = 4'd0; ex_wdata = 32'h77; dbus_ack = 1'b1; dbus_rdata = $urandom; #1;
        chk("rb_req", dbus_req, 0);
        chk("rb_late_stall", stallreq, 0);
        chk("rb_late_data", mem_wdata, 32'h77);
        @(negedge clk);
        dbus_ack = 1'b0; #1;
        chk("rb_req2", dbus_req, 0);
        chk("rb_err", bus_err, 0);

`ifdef ALIGN_CHECK_EN
        @(negedge clk);
        ex_mem_op = 4'd5; ex_mem_addr = 32'h102; ex_wreg = 1'b1; #1;
        chk("al_stall", stallreq, 0);
        chk("al_wreg", mem_wreg, 0);
        chk("al_excp", mem_excp_align, 1);
        @(negedge clk); #1;
        chk("al_req", dbus_req, 0);
        ex_mem_op = 4'd0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
